// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART matrix loader: default frame geometry,
//   the default frame header byte and the loader state encoding.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int         MAT_ROWS      = 10;
  localparam int         MAT_COLS      = 10;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/uart_byte_strobe.sv
// ---------------------------------------------------------------------------
// uart_byte_strobe
//   Turns the UART receiver's ready level into a single-cycle byte strobe on
//   its rising edge and presents the received byte alongside it.
//
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    byte from the UART receiver
//   i_rx_ready   receiver ready level (held high for about one bit time)
//   o_byte_stb   one-cycle strobe on the 0->1 edge of i_rx_ready
//   o_byte_val   byte to be sampled in the same cycle as o_byte_stb
// ---------------------------------------------------------------------------
module uart_byte_strobe
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic       o_byte_stb,
  output logic [7:0] o_byte_val
);

  logic r_rx_ready_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_ready_q <= 1'b0;
    end else begin
      r_rx_ready_q <= i_rx_ready;
    end
  end

  // A ready level held high only ever yields the first-cycle strobe.
  assign o_byte_stb = i_rx_ready & ~r_rx_ready_q;
  assign o_byte_val = i_rx_data;

endmodule

// File: rtl/uart_matrix_loader.sv
// ---------------------------------------------------------------------------
// uart_matrix_loader
//   Collects one framed ROWS x COLS matrix of bytes from the UART receiver
//   (header byte SYNC_BYTE followed by ROWS*COLS data bytes) into a local
//   buffer, then streams it out row-major over a valid/ready handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for the frame header byte, other bytes discarded
//   LOAD  | storing data bytes; inter-byte timeout aborts the frame
//   DRAIN | presenting buffer elements until the last one is accepted
//
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_data    byte from the UART receiver
//   i_rx_ready   receiver ready level
//   o_out_data   matrix element
//   o_out_row    row index of o_out_data
//   o_out_col    column index of o_out_data
//   o_out_valid  element outputs valid
//   i_out_ready  downstream accepts when o_out_valid & i_out_ready
//   o_out_last   high with the final element
//   o_busy       frame in progress (LOAD or DRAIN)
//   o_frame_err  one-cycle pulse when a frame is aborted on timeout
//   o_overrun    sticky; a byte arrived during DRAIN and was dropped
// ---------------------------------------------------------------------------
module uart_matrix_loader
  import uart_pkg::*;
#(
  parameter int         ROWS           = MAT_ROWS,
  parameter int         COLS           = MAT_COLS,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_ready,
  output logic [7:0] o_out_data,
  output logic [3:0] o_out_row,
  output logic [3:0] o_out_col,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int NELEM = ROWS * COLS;
  localparam int IDX_W = $clog2(NELEM);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_COL = 4'(COLS - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_byte_stb;
  logic [7:0]       w_byte_val;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_rd_idx;
  logic [TMR_W-1:0] r_timer;
  logic [3:0]       r_row;
  logic [3:0]       r_col;
  logic             r_frame_err;
  logic             r_overrun;
  logic [7:0]       r_buf [NELEM];
  logic             w_timeout;
  logic             w_last;
  logic             w_handshake;

  uart_byte_strobe u_byte_strobe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_data  (i_rx_data),
    .i_rx_ready (i_rx_ready),
    .o_byte_stb (w_byte_stb),
    .o_byte_val (w_byte_val)
  );

  // A strobe in the timeout cycle keeps the frame alive.
  assign w_timeout   = (r_state == LOAD) && !w_byte_stb && (r_timer == TMR_LAST);
  assign w_last      = (r_state == DRAIN) && (r_rd_idx == LAST_IDX);
  assign w_handshake = (r_state == DRAIN) && i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_byte_stb && (w_byte_val == SYNC_BYTE)) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (w_byte_stb && (r_wr_idx == LAST_IDX)) w_state_nxt = DRAIN;
        else if (w_timeout)                       w_state_nxt = IDLE;
      end
      DRAIN: begin
        if (w_handshake && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_timer     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;
      unique case (r_state)
        IDLE: begin
          if (w_byte_stb && (w_byte_val == SYNC_BYTE)) begin
            r_wr_idx <= '0;
            r_timer  <= '0;
          end
        end
        LOAD: begin
          if (w_byte_stb) begin
            r_wr_idx <= r_wr_idx + 1'b1;
            r_timer  <= '0;
            if (r_wr_idx == LAST_IDX) begin
              r_rd_idx <= '0;
              r_row    <= '0;
              r_col    <= '0;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DRAIN: begin
          if (w_byte_stb) r_overrun <= 1'b1;
          if (w_handshake) begin
            r_rd_idx <= r_rd_idx + 1'b1;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Matrix storage is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if ((r_state == LOAD) && w_byte_stb) r_buf[r_wr_idx] <= w_byte_val;
  end

  // Element outputs are forced to zero outside DRAIN so the unreset buffer
  // never leaks onto the bus.
  assign o_out_valid = (r_state == DRAIN);
  assign o_out_data  = o_out_valid ? r_buf[r_rd_idx] : 8'h00;
  assign o_out_row   = o_out_valid ? r_row : 4'h0;
  assign o_out_col   = o_out_valid ? r_col : 4'h0;
  assign o_out_last  = w_last;
  assign o_busy      = (r_state != IDLE);
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_matrix_loader
//   Self-checking bench for uart_matrix_loader. Frames are built from
//   $urandom data; the expected stream is derived directly from the frame
//   contents (element i -> row i/COLS, col i%COLS, last on i == N-1).
// ---------------------------------------------------------------------------
module tb_uart_matrix_loader;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;
  localparam int TMO  = 1000;
  localparam int HOLD = 50;
  localparam int GAP  = 5;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_ready  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_row;
  logic [3:0] out_col;
  logic       out_valid;
  logic       out_last;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_matrix_loader #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_ready  (rx_ready),
    .o_out_data  (out_data),
    .o_out_row   (out_row),
    .o_out_col   (out_col),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] r;
    logic [3:0] c;
    logic       l;
    int         t;
  } elem_t;

  elem_t      mon_q[$];
  int         n_valid_cyc  = 0;
  int         n_ferr_cyc   = 0;
  int         n_stall_viol = 0;
  logic       p_v = 1'b0;
  logic       p_rdy = 1'b0;
  logic [7:0] p_d = 8'h00;
  logic [3:0] p_r = 4'h0;
  logic [3:0] p_c = 4'h0;
  logic       p_l = 1'b0;

  // Passive monitor: records handshakes, counts valid/frame_err cycles and
  // flags any change of a stalled element.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_v <= 1'b0;
    end else begin
      if (out_valid) n_valid_cyc <= n_valid_cyc + 1;
      if (frame_err) n_ferr_cyc <= n_ferr_cyc + 1;
      if (p_v && !p_rdy &&
          !(out_valid && out_data == p_d && out_row == p_r && out_col == p_c && out_last == p_l))
        n_stall_viol <= n_stall_viol + 1;
      if (out_valid && out_ready) mon_q.push_back('{out_data, out_row, out_col, out_last, cyc});
      p_v   <= out_valid;
      p_rdy <= out_ready;
      p_d   <= out_data;
      p_r   <= out_row;
      p_c   <= out_col;
      p_l   <= out_last;
    end
  end

  int         n_pass = 0;
  int         n_chk  = 0;
  int         last_raise = 0;
  logic [7:0] exp_frame [N];

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data    = b;
    rx_ready   = 1'b1;
    last_raise = cyc;
    repeat (HOLD) @(posedge clk);
    #1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    repeat (GAP) @(posedge clk);
  endtask

  task automatic send_frame();
    send_byte(8'hA5);
    for (int i = 0; i < N; i++) send_byte(exp_frame[i]);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) exp_frame[i] = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%0b required 0", tag, busy);
    else n_pass++;
  endtask

  task automatic check_frame(input int base, input string tag);
    logic [16:0] got;
    logic [16:0] exp;
    n_chk++;
    if (mon_q.size() - base !== N)
      $display("FAIL %s_count: handshakes=%0d required %0d", tag, mon_q.size() - base, N);
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      exp = {exp_frame[i], 4'(i / COLS), 4'(i % COLS), (i == N - 1)};
      n_chk++;
      if (base + i >= mon_q.size()) begin
        $display("FAIL %s_elem%0d: missing, required %h", tag, i, exp);
      end else begin
        got = {mon_q[base+i].d, mon_q[base+i].r, mon_q[base+i].c, mon_q[base+i].l};
        if (got !== exp) $display("FAIL %s_elem%0d: got %h required %h", tag, i, got, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({out_valid, out_last, busy, frame_err, overrun, out_data, out_row, out_col} !== 21'h0)
      $display("FAIL reset_hold: outputs=%h required 0",
               {out_valid, out_last, busy, frame_err, overrun, out_data, out_row, out_col});
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({out_valid, out_last, busy, frame_err, overrun} !== 5'h0)
      $display("FAIL reset_release: flags=%b required 00000",
               {out_valid, out_last, busy, frame_err, overrun});
    else n_pass++;
  endtask

  task automatic test_basic();
    int base, f0;
    for (int i = 0; i < N; i++) exp_frame[i] = 8'(i);
    out_ready = 1'b1;
    base = mon_q.size();
    f0   = n_ferr_cyc;
    send_frame();
    wait_idle("basic");
    check_frame(base, "basic");
    if (mon_q.size() - base == N) begin
      n_chk++;
      if (mon_q[base].t !== last_raise + 1)
        $display("FAIL basic_latency: first at cycle %0d required %0d", mon_q[base].t, last_raise + 1);
      else n_pass++;
      n_chk++;
      if (mon_q[base+N-1].t - mon_q[base].t !== N - 1)
        $display("FAIL basic_throughput: span=%0d required %0d",
                 mon_q[base+N-1].t - mon_q[base].t, N - 1);
      else n_pass++;
    end
    n_chk++;
    if (n_ferr_cyc - f0 !== 0) $display("FAIL basic_ferr: pulses=%0d required 0", n_ferr_cyc - f0);
    else n_pass++;
  endtask

  task automatic test_junk();
    int base, f0;
    f0 = n_ferr_cyc;
    send_byte(8'h3C);
    send_byte(8'h7E);
    n_chk++;
    if (busy !== 1'b0) $display("FAIL junk_ignored: busy=%0b required 0", busy);
    else n_pass++;
    rand_frame();
    exp_frame[0] = 8'hA5;
    exp_frame[7] = 8'hA5;
    base = mon_q.size();
    send_frame();
    wait_idle("junk");
    check_frame(base, "junk");
    n_chk++;
    if (n_ferr_cyc - f0 !== 0) $display("FAIL junk_ferr: pulses=%0d required 0", n_ferr_cyc - f0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int base, f0, v0;
    f0 = n_ferr_cyc;
    v0 = n_valid_cyc;
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) send_byte(8'($urandom));
    n_chk++;
    if (busy !== 1'b1) $display("FAIL timeout_loading: busy=%0b required 1", busy);
    else n_pass++;
    repeat (TMO + 100) @(negedge clk);
    n_chk++;
    if (n_ferr_cyc - f0 !== 1) $display("FAIL timeout_pulse: cycles=%0d required 1", n_ferr_cyc - f0);
    else n_pass++;
    n_chk++;
    if (n_valid_cyc - v0 !== 0) $display("FAIL timeout_novalid: cycles=%0d required 0", n_valid_cyc - v0);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%0b required 0", busy);
    else n_pass++;
    rand_frame();
    base = mon_q.size();
    send_frame();
    wait_idle("timeout_next");
    check_frame(base, "timeout_next");
  endtask

  task automatic test_stall();
    int base, s0, v0, dv;
    rand_frame();
    out_ready = 1'b0;
    base = mon_q.size();
    s0   = n_stall_viol;
    v0   = n_valid_cyc;
    fork
      send_frame();
      begin
        for (int k = 0; k < 20000; k++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
          if (mon_q.size() - base >= N) break;
        end
      end
    join
    out_ready = 1'b1;
    wait_idle("stall");
    check_frame(base, "stall");
    n_chk++;
    if (n_stall_viol - s0 !== 0) $display("FAIL stall_stable: violations=%0d required 0", n_stall_viol - s0);
    else n_pass++;
    dv = n_valid_cyc - v0;
    n_chk++;
    if (dv < 2 * N - 1 || dv > 2 * N) $display("FAIL stall_valid_cycles: got %0d required %0d..%0d", dv, 2 * N - 1, 2 * N);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int base;
    rand_frame();
    out_ready = 1'b0;
    base = mon_q.size();
    send_frame();
    n_chk++;
    if (overrun !== 1'b0) $display("FAIL overrun_pre: overrun=%0b required 0", overrun);
    else n_pass++;
    send_byte(8'h55);
    @(negedge clk);
    n_chk++;
    if ({overrun, busy, out_valid} !== 3'b111)
      $display("FAIL overrun_set: overrun/busy/valid=%b required 111", {overrun, busy, out_valid});
    else n_pass++;
    out_ready = 1'b1;
    wait_idle("overrun");
    check_frame(base, "overrun");
    n_chk++;
    if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%0b required 1", overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    send_byte(8'hA5);
    for (int i = 0; i < 50; i++) send_byte(8'($urandom));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, out_last, busy, frame_err, overrun, out_data, out_row, out_col} !== 21'h0)
      $display("FAIL midreset_async: outputs=%h required 0",
               {out_valid, out_last, busy, frame_err, overrun, out_data, out_row, out_col});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_frame();
    out_ready = 1'b1;
    base = mon_q.size();
    send_frame();
    wait_idle("midreset");
    check_frame(base, "midreset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk();
    test_timeout();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
